spi_slave_regfile: RTL and testbench

SPI responder that serves the chip-side end of the FPGA's single-byte write/read command transactions. It decodes 16-bit SPI frames (command/address byte, then data byte) into writes and reads of a local 8-bit register bank. During reads it shifts the addressed register back on MISO. It is the bench model and loopback target for the FPGA SPI master path, and the reference register bank for on-chip integration.

---
 rtl/spi_slave_regfile.sv | 180 ++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile
//   SPI mode-0 responder that decodes 16-bit frames ({rw, addr[6:0]}, data)
//   into writes and reads of a local bank of NUM_REGS 8-bit registers.
//   All SPI pins are asynchronous to CLK and are synchronized internally.
//
// Ports
//   CLK        process clock (SCLK must be at most CLK/8)
//   rst_n      synchronous active-low reset
//   SCLK       SPI clock, idle low
//   CS_N       SPI chip select, active low
//   MOSI       SPI data in, MSB first
//   MISO       SPI data out, MSB first
//   MISO_OE    MISO drive enable, high only inside a read frame
//   wr_strobe  one-CLK pulse when a write commits
//   wr_addr    address of the last committed write
//   wr_data    data of the last committed write
//   rd_strobe  one-CLK pulse when read data is loaded for shifting
//   reg_flat   register bank, reg i at bits [8i+7:8i]
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | CS_N high (or not yet seen high since reset); nothing shifting
// CMD   | shifting in the command/address byte
// DATA  | shifting in write data or shifting out read data
// DONE  | frame complete; extra SCLK edges are ignored until CS_N rises
module spi_slave_regfile #(
  parameter int          NUM_REGS = 16,
  parameter logic [7:0]  RST_VAL  = 8'h00
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  SCLK,
  input  logic                  CS_N,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_OE,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic [7:0]            wr_data,
  output logic                  rd_strobe,
  output logic [8*NUM_REGS-1:0] reg_flat
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

  state_t      state;
  logic        sclk_s1, sclk_s2, sclk_s3;
  logic        cs_s1, cs_s2;
  logic        mosi_s1, mosi_s2;
  logic [1:0]  fill;
  logic        armed;
  logic [3:0]  bit_cnt;
  logic [6:0]  shift_in;
  logic [7:0]  shift_out;
  logic        rw;
  logic [6:0]  addr;
  logic [7:0]  regs [NUM_REGS];
  logic [7:0]  rd_val;
  logic [7:0]  byte_in;
  logic        sclk_rise;
  logic        sclk_fall;

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign byte_in   = {shift_in, mosi_s2};

  // Out-of-range addresses match no register and read back as zero.
  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == 7'(i)) rd_val = regs[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_flat[8*g +: 8] = regs[g];
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_s3   <= 1'b0;
      cs_s1     <= 1'b1;
      cs_s2     <= 1'b1;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
      fill      <= 2'b00;
      armed     <= 1'b0;
      bit_cnt   <= 4'd0;
      shift_in  <= 7'd0;
      shift_out <= 8'h00;
      rw        <= 1'b0;
      addr      <= 7'd0;
      MISO      <= 1'b0;
      MISO_OE   <= 1'b0;
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      wr_addr   <= 7'd0;
      wr_data   <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
    end else begin
      sclk_s1 <= SCLK;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_s1   <= CS_N;
      cs_s2   <= cs_s1;
      mosi_s1 <= MOSI;
      mosi_s2 <= mosi_s1;

      // The synchronizers hold idle values for two cycles after reset, so
      // a CS_N that stayed low through reset is not mistaken for a new
      // frame: a real high level must be observed before IDLE may leave.
      fill <= {fill[0], 1'b1};
      if (fill[1] && cs_s2) armed <= 1'b1;

      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;

      if (cs_s2) begin
        state   <= S_IDLE;
        bit_cnt <= 4'd0;
        MISO    <= 1'b0;
        MISO_OE <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (armed) begin
              state   <= S_CMD;
              bit_cnt <= 4'd0;
            end
          end
          S_CMD: begin
            if (sclk_rise) begin
              shift_in <= byte_in[6:0];
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                rw    <= byte_in[7];
                addr  <= byte_in[6:0];
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (sclk_rise) begin
              shift_in <= byte_in[6:0];
              if (bit_cnt == 4'd15) begin
                state <= S_DONE;
                if (rw) begin
                  wr_strobe <= 1'b1;
                  wr_addr   <= addr;
                  wr_data   <= byte_in;
                  for (int i = 0; i < NUM_REGS; i++) begin
                    if (addr == 7'(i)) regs[i] <= byte_in;
                  end
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end else if (sclk_fall && !rw) begin
              // The first fall in DATA always arrives with bit_cnt still 8.
              if (bit_cnt == 4'd8) begin
                shift_out <= rd_val;
                MISO      <= rd_val[7];
                MISO_OE   <= 1'b1;
                rd_strobe <= 1'b1;
              end else begin
                shift_out <= {shift_out[6:0], 1'b0};
                MISO      <= shift_out[6];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb_spi_slave_regfile
//   Drives SPI mode-0 frames into spi_slave_regfile and checks strobes,
//   write address/data, read-back data on MISO, MISO/MISO_OE quiet levels
//   and the register bank against a register-array model of the bank.
module tb_spi_slave_regfile;

  localparam int NR = 16;

  logic            CLK = 1'b0;
  logic            rst_n = 1'b0;
  logic            SCLK = 1'b0;
  logic            CS_N = 1'b1;
  logic            MOSI = 1'b0;
  logic            MISO;
  logic            MISO_OE;
  logic            wr_strobe;
  logic [6:0]      wr_addr;
  logic [7:0]      wr_data;
  logic            rd_strobe;
  logic [8*NR-1:0] reg_flat;

  spi_slave_regfile #(.NUM_REGS(NR), .RST_VAL(8'h00)) dut (
    .CLK(CLK), .rst_n(rst_n), .SCLK(SCLK), .CS_N(CS_N), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_strobe(rd_strobe), .reg_flat(reg_flat)
  );

  always #5 CLK = ~CLK;

  logic [7:0] model [NR];
  int         n_chk = 0;
  int         n_fail = 0;
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  int         cs_hi_cnt = 0;
  bit         idle_chk = 1'b0;
  logic [6:0] exp_wr_addr = 7'd0;
  logic [7:0] exp_wr_data = 8'h00;
  logic [7:0] last_cap = 8'h00;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) f[8*i +: 8] = model[i];
    return f;
  endfunction

  // Single compare process: strobe bookkeeping, quiet-bus rules and the
  // register bank whenever the model is current.
  always @(negedge CLK) begin
    if (CS_N) cs_hi_cnt++;
    else cs_hi_cnt = 0;
    if (wr_strobe === 1'b1) begin
      wr_cnt++;
      chk("wr_addr", 128'(wr_addr), 128'(exp_wr_addr));
      chk("wr_data", 128'(wr_data), 128'(exp_wr_data));
    end
    if (rd_strobe === 1'b1) rd_cnt++;
    if (MISO_OE === 1'b0) chk("miso_quiet", 128'(MISO), 128'(0));
    if (cs_hi_cnt >= 4) begin
      chk("oe_idle", 128'(MISO_OE), 128'(0));
      chk("miso_idle", 128'(MISO), 128'(0));
    end
    if (idle_chk) chk("reg_flat", 128'(reg_flat), model_flat());
  end

  // One SCLK period: MOSI set while SCLK low, MISO sampled as SCLK rises.
  task automatic sclk_bit(input logic b, input int h, output logic s);
    MOSI = b;
    repeat (h) @(negedge CLK);
    SCLK = 1'b1;
    s = MISO;
    repeat (h) @(negedge CLK);
    SCLK = 1'b0;
  endtask

  // bits is left-aligned: first bit on the wire is bits[23].
  task automatic frame(input int nbits, input logic [23:0] bits, input int h, input int gap);
    logic [7:0] b0, b1, cap, exp_rd_data;
    logic       s, is_wr, exp_commit, exp_rd;
    int         a, wr0, rd0;
    b0 = bits[23:16];
    b1 = bits[15:8];
    is_wr = b0[7];
    a = int'(b0[6:0]);
    exp_commit = is_wr && (nbits >= 16);
    exp_rd = !is_wr && (nbits >= 8);
    exp_rd_data = (a < NR) ? model[a] : 8'h00;
    exp_wr_addr = b0[6:0];
    exp_wr_data = b1;
    cap = 8'h00;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    idle_chk = 1'b0;
    @(negedge CLK);
    CS_N = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      sclk_bit(bits[23-i], h, s);
      if (i >= 8 && i < 16) cap[15-i] = s;
    end
    repeat (h) @(negedge CLK);
    CS_N = 1'b1;
    MOSI = 1'b0;
    repeat (gap) @(negedge CLK);
    chk("wr_strobe_count", 128'(wr_cnt - wr0), 128'(exp_commit ? 1 : 0));
    chk("rd_strobe_count", 128'(rd_cnt - rd0), 128'(exp_rd ? 1 : 0));
    if (exp_rd && nbits >= 16) chk("read_data", 128'(cap), 128'(exp_rd_data));
    last_cap = cap;
    if (exp_commit && a < NR) model[a] = b1;
    idle_chk = 1'b1;
  endtask

  initial begin
    logic       s;
    logic [7:0] d;
    int         nb, r, wr0;

    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    repeat (3) @(negedge CLK);
    chk("rst_miso", 128'(MISO), 128'(0));
    chk("rst_miso_oe", 128'(MISO_OE), 128'(0));
    chk("rst_wr_strobe", 128'(wr_strobe), 128'(0));
    chk("rst_rd_strobe", 128'(rd_strobe), 128'(0));
    chk("rst_wr_addr", 128'(wr_addr), 128'(0));
    chk("rst_wr_data", 128'(wr_data), 128'(0));
    chk("rst_regs", 128'(reg_flat), 128'(0));
    rst_n = 1'b1;
    repeat (4) @(negedge CLK);
    idle_chk = 1'b1;

    // Reset values read back through MISO.
    for (int a = 0; a < NR; a++) begin
      frame(16, {1'b0, 7'(a), 16'h0000}, 4, 6);
      chk("rst_readback", 128'(last_cap), 128'(0));
    end

    // Write then read back.
    frame(16, 24'h853C00, 4, 6);
    chk("wr5_addr", 128'(wr_addr), 128'(5));
    chk("wr5_data", 128'(wr_data), 128'(8'h3C));
    chk("wr5_reg", 128'(reg_flat[47:40]), 128'(8'h3C));
    frame(16, 24'h050000, 4, 6);
    chk("rd5_data", 128'(last_cap), 128'(8'h3C));

    // Aborted frame then a full one to the same register.
    frame(12, 24'h82FF00, 4, 6);
    chk("abort_reg2", 128'(reg_flat[23:16]), 128'(0));
    frame(16, 24'h821100, 4, 6);
    chk("reg2_after", 128'(reg_flat[23:16]), 128'(8'h11));

    // Out-of-range write and read.
    frame(16, 24'h9FAA00, 4, 6);
    chk("oor_wr_addr", 128'(wr_addr), 128'(7'h1F));
    chk("oor_regs", 128'(reg_flat), model_flat());
    frame(16, 24'h1F0000, 4, 6);
    chk("oor_rd", 128'(last_cap), 128'(0));

    // Overlong frame.
    frame(24, 24'h815AFF, 4, 6);
    chk("overlong_reg1", 128'(reg_flat[15:8]), 128'(8'h5A));

    // Back-to-back at SCLK = CLK/8 with one SCLK period of CS_N high.
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      frame(16, {1'b1, 7'(k + 8), d, 8'h00}, 4, 7);
    end
    for (int k = 0; k < 8; k++) frame(16, {1'b0, 7'(k + 8), 16'h0000}, 4, 7);

    // Randomized frames: mixed lengths, directions and address ranges.
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6) nb = 16;
      else if (r == 6) nb = 12;
      else if (r == 7) nb = 20;
      else if (r == 8) nb = 24;
      else nb = $urandom_range(1, 15);
      frame(nb, {1'($urandom), 7'($urandom_range(0, 31)), 16'($urandom)},
            $urandom_range(4, 6), $urandom_range(6, 12));
    end

    // Synchronous reset in the middle of a read frame.
    idle_chk = 1'b0;
    @(negedge CLK);
    CS_N = 1'b0;
    for (int i = 0; i < 11; i++) sclk_bit(i < 8 ? ((8'h03 >> (7 - i)) & 8'h01) != 0 : 1'b0, 4, s);
    chk("midread_oe", 128'(MISO_OE), 128'(1));
    rst_n = 1'b0;
    @(negedge CLK);
    chk("midrst_miso", 128'(MISO), 128'(0));
    chk("midrst_oe", 128'(MISO_OE), 128'(0));
    chk("midrst_regs", 128'(reg_flat), 128'(0));
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    @(negedge CLK);
    rst_n = 1'b1;
    // CS_N never went high: this whole frame must be ignored.
    wr0 = wr_cnt;
    exp_wr_addr = 7'd1;
    exp_wr_data = 8'h77;
    for (int i = 0; i < 16; i++) sclk_bit(((16'h8177 >> (15 - i)) & 16'h1) != 0, 4, s);
    repeat (4) @(negedge CLK);
    CS_N = 1'b1;
    repeat (8) @(negedge CLK);
    chk("no_resync_wr", 128'(wr_cnt - wr0), 128'(0));
    idle_chk = 1'b1;
    frame(16, 24'h817700, 4, 6);
    chk("resync_reg1", 128'(reg_flat[15:8]), 128'(8'h77));
    frame(16, 24'h010000, 5, 6);
    chk("resync_rd1", 128'(last_cap), 128'(8'h77));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
